// File: rtl/ahb_defs_pkg.sv
// Shared AHB-lite definitions: transfer type, burst and response encodings,
// and the burst-length lookup used by the arbiter beat counter.
package ahb_defs_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam int BEAT_CNT_W = 4;

    // Beats remaining after the NONSEQ beat of a burst. SINGLE and
    // undefined-length INCR return 0.
    function automatic logic [BEAT_CNT_W-1:0] burst_beats_m1(input logic [2:0] hburst);
        logic [BEAT_CNT_W-1:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signal bundle between the bus masters and the AHB arbiter.
//   hbusreq / hlock : per-master request and locked-transfer request
//   htrans / hburst : muxed from the current address-phase owner
//   hready / hresp  : bus-wide completion and response
//   hgrant          : one-hot grant
//   hmaster         : address-phase owner index
//   hmaster_d       : data-phase owner index
//   hmastlock       : current address phase belongs to a locked sequence
// Modport master is the requesting side, modport slave is the arbiter.
interface ahb_bus_arbiter_if #(
    parameter int NUM_M = 2,
    parameter int MW    = 1
);
    logic [NUM_M-1:0] hbusreq;
    logic [NUM_M-1:0] hlock;
    logic [1:0]       htrans;
    logic [2:0]       hburst;
    logic             hready;
    logic [1:0]       hresp;
    logic [NUM_M-1:0] hgrant;
    logic [MW-1:0]    hmaster;
    logic [MW-1:0]    hmaster_d;
    logic             hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp,
        output hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational winner selection.
//   req   : request vector
//   ptr   : last owner (round-robin starts searching at ptr+1)
//   rr_en : 0 fixed priority (index 0 highest), 1 round-robin
//   idx   : winning index, vld : at least one request present
module ahb_arb_pick #(
    parameter int NUM_M = 2,
    parameter int MW    = 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [MW-1:0]    ptr,
    input  logic             rr_en,
    output logic [MW-1:0]    idx,
    output logic             vld
);

    // One extra bit so ptr + NUM_M cannot overflow before the wrap.
    logic [MW:0]   cand_w;
    logic [MW-1:0] cand;

    always_comb begin
        idx    = '0;
        vld    = 1'b0;
        cand_w = '0;
        cand   = '0;
        if (rr_en) begin
            for (int i = 1; i <= NUM_M; i++) begin
                cand_w = {1'b0, ptr} + (MW+1)'(i);
                if (cand_w >= (MW+1)'(NUM_M)) begin
                    cand_w = cand_w - (MW+1)'(NUM_M);
                end
                cand = cand_w[MW-1:0];
                if (!vld && req[cand]) begin
                    vld = 1'b1;
                    idx = cand;
                end
            end
        end else begin
            // Descending scan: the last hit is the lowest index.
            for (int i = NUM_M-1; i >= 0; i--) begin
                if (req[i]) begin
                    vld = 1'b1;
                    idx = MW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-lite bus arbiter. Decides which master owns the shared address path
// and tracks the data-phase owner; the address/wdata muxes live outside.
// Bursts, locked sequences and wait states are never broken. Parks on
// DEFAULT_M when nobody requests.
//   hclk   : system clock
//   hreset : synchronous reset, active-high
//   bus    : arbitration bundle (slave modport), see ahb_bus_arbiter_if
module ahb_bus_arbiter
    import ahb_defs_pkg::*;
#(
    parameter int NUM_M     = 2,
    parameter int MW        = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    parameter bit RR_EN     = 1'b0,
    parameter int DEFAULT_M = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_bus_arbiter_if.slave bus
);

    localparam logic [MW-1:0]    DEF_IDX   = MW'(DEFAULT_M);
    localparam logic [NUM_M-1:0] DEF_GRANT = NUM_M'(1) << DEFAULT_M;

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_CNT_W-1:0] beat_cnt_nxt;
    logic                  lock_hold;
    logic                  lock_nxt;
    logic [MW-1:0]         hmaster_q;
    logic [MW-1:0]         hmaster_d_q;
    logic [NUM_M-1:0]      hgrant_q;
    logic [MW-1:0]         rr_ptr;
    logic [MW-1:0]         pick_idx;
    logic                  pick_vld;
    logic [MW-1:0]         winner;

    logic owner_req;
    logic owner_lock;
    logic nonseq_acc;
    logic seq_acc;
    logic idle_acc;
    logic err_acc;
    logic incr_hold;
    logic arb_ok;

    assign owner_req  = bus.hbusreq[hmaster_q];
    assign owner_lock = bus.hlock[hmaster_q];

    assign nonseq_acc = bus.hready & (bus.htrans == HTRANS_NONSEQ);
    assign seq_acc    = bus.hready & (bus.htrans == HTRANS_SEQ);
    assign idle_acc   = bus.hready & (bus.htrans == HTRANS_IDLE);
    assign err_acc    = bus.hready & (bus.hresp != HRESP_OKAY);

    // Undefined-length INCR runs as long as its owner keeps requesting.
    assign incr_hold  = (bus.hburst == HBURST_INCR) & (bus.htrans != HTRANS_IDLE) & owner_req;

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (err_acc) begin
            beat_cnt_nxt = '0;
        end else if (nonseq_acc) begin
            beat_cnt_nxt = burst_beats_m1(bus.hburst);
        end else if (seq_acc && beat_cnt != '0) begin
            beat_cnt_nxt = beat_cnt - 4'd1;
        end
    end

    always_comb begin
        lock_nxt = lock_hold;
        if (err_acc) begin
            lock_nxt = 1'b0;
        end else if (nonseq_acc || seq_acc) begin
            lock_nxt = owner_lock;
        end else if (idle_acc && !owner_lock) begin
            lock_nxt = 1'b0;
        end
    end

    // Arbitrate on the post-edge counter and lock values: this keeps the
    // NONSEQ of a multi-beat burst and the first beat of a locked sequence
    // from handing the bus away, while the last SEQ (count 1 -> 0) and the
    // IDLE that drops HLOCK are arbitration points.
    assign arb_ok = err_acc |
                    (bus.hready & (beat_cnt_nxt == '0) & ~lock_nxt & ~incr_hold);

    ahb_arb_pick #(
        .NUM_M (NUM_M),
        .MW    (MW)
    ) u_pick (
        .req   (bus.hbusreq),
        .ptr   (rr_ptr),
        .rr_en (RR_EN),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    assign winner = pick_vld ? pick_idx : DEF_IDX;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            beat_cnt    <= '0;
            lock_hold   <= 1'b0;
            hmaster_q   <= DEF_IDX;
            hmaster_d_q <= DEF_IDX;
            hgrant_q    <= DEF_GRANT;
            rr_ptr      <= DEF_IDX;
        end else if (bus.hready) begin
            beat_cnt    <= beat_cnt_nxt;
            lock_hold   <= lock_nxt;
            hmaster_d_q <= hmaster_q;
            if (arb_ok) begin
                hmaster_q <= winner;
                hgrant_q  <= NUM_M'(1) << winner;
                if (RR_EN) begin
                    rr_ptr <= winner;
                end
            end
        end
    end

    assign bus.hmaster   = hmaster_q;
    assign bus.hmaster_d = hmaster_d_q;
    assign bus.hgrant    = hgrant_q;
    // Locked if the sequence is already held or the owner is requesting a
    // lock for the transfer it is presenting now.
    assign bus.hmastlock = (lock_hold | owner_lock) & (bus.htrans != HTRANS_IDLE);

endmodule
